// File: rtl/pc_fetch_unit.sv
//============================================================================
// Module   : pc_fetch_unit
// Purpose  : Program counter and next-PC stage of a single-cycle MIPS core.
//            Holds the PC, selects the next fetch address from the decoder's
//            PCSel/BranchControl, the ALU zero flag and the jr target, and
//            provides the jal link value, a BOOT/RUN/HALT sequencer and a
//            saturating retired-instruction counter.
// Option   : PC_MISALIGN_TRAP_EN - when defined, a misaligned next PC (only
//            reachable through jr) stops the core in TRAP and raises 'trap'.
// Ports    : clk, rst_n (async, active low), stall, instr[31:0],
//            pc_sel[1:0], branch_ctrl, alu_zero, jr_target[31:0]
//            -> pc_addr[ADDR_W-1:0], pc[31:0], link_addr[31:0],
//               fetch_valid, halted, instr_count[31:0] (+ trap if enabled)
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module pc_fetch_unit #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [31:0]       instr,
  input  logic [1:0]        pc_sel,
  input  logic              branch_ctrl,
  input  logic              alu_zero,
  input  logic [31:0]       jr_target,
  output logic [ADDR_W-1:0] pc_addr,
  output logic [31:0]       pc,
  output logic [31:0]       link_addr,
  output logic              fetch_valid,
  output logic              halted,
`ifdef PC_MISALIGN_TRAP_EN
  output logic              trap,
`endif
  output logic [31:0]       instr_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
`ifdef PC_MISALIGN_TRAP_EN
    TRAP = 2'd3,
`endif
    HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] seq_pc, br_pc, jmp_pc, next_pc;
  logic        retire;

  // Opcode bits are decoded upstream; they are not needed here.
  logic        unused_opcode;
  assign unused_opcode = ^instr[31:26];

  assign seq_pc = pc_q + 32'd4;
  assign br_pc  = seq_pc + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign jmp_pc = {seq_pc[31:28], instr[25:0], 2'b00};

  always_comb begin
    next_pc = seq_pc;
    case (pc_sel)
      2'b00:   next_pc = jmp_pc;
      2'b01:   next_pc = jr_target;
      // BranchControl low means bne; it is taken when the ALU result is nonzero.
      2'b10:   next_pc = (!branch_ctrl && !alu_zero) ? br_pc : seq_pc;
      default: next_pc = seq_pc;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    retire  = 1'b0;
    case (state_q)
      // One dead cycle so the negedge decoder can settle on the first word.
      BOOT: state_d = RUN;
      RUN: begin
        if (!stall) begin
          retire = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
          if (next_pc[1:0] != 2'b00) begin
            retire  = 1'b0;
            state_d = TRAP;
          end
`endif
        end
        if (retire) begin
          pc_d  = next_pc;
          cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
          // A self-loop ("j ." style) is the program's way of ending.
          if (next_pc == pc_q) state_d = HALT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign pc_addr     = pc_q[ADDR_W-1:0];
  assign link_addr   = seq_pc;
  assign instr_count = cnt_q;
  assign fetch_valid = (state_q == RUN);
`ifdef PC_MISALIGN_TRAP_EN
  assign trap        = (state_q == TRAP);
  assign halted      = (state_q == HALT) || (state_q == TRAP);
`else
  assign halted      = (state_q == HALT);
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
//============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Self-checking bench for pc_fetch_unit: directed scenarios with
//            literal expectations, then randomized traffic compared every
//            cycle against a behavioural model of the fetch stage.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_pc_fetch_unit;

  localparam int          ADDR_W    = 10;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] ADDI      = 32'h2008_0001;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              stall = 1'b0;
  logic [31:0]       instr = ADDI;
  logic [1:0]        pc_sel = 2'b10;
  logic              branch_ctrl = 1'b1;
  logic              alu_zero = 1'b0;
  logic [31:0]       jr_target = 32'd0;
  logic [ADDR_W-1:0] pc_addr;
  logic [31:0]       pc, link_addr, instr_count;
  logic              fetch_valid, halted;
`ifdef PC_MISALIGN_TRAP_EN
  logic              trap;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.ADDR_W(ADDR_W), .RESET_VEC(RESET_VEC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .instr(instr),
    .pc_sel(pc_sel), .branch_ctrl(branch_ctrl), .alu_zero(alu_zero),
    .jr_target(jr_target), .pc_addr(pc_addr), .pc(pc),
    .link_addr(link_addr), .fetch_valid(fetch_valid), .halted(halted),
`ifdef PC_MISALIGN_TRAP_EN
    .trap(trap),
`endif
    .instr_count(instr_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_boot, m_run, m_halt, m_trap;

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] iw,
                                             input logic [1:0] sel, input logic bc,
                                             input logic z, input logic [31:0] jr);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = int'($signed(iw[15:0])) * 4;
    case (sel)
      2'b00:   return {seq[31:28], iw[25:0], 2'b00};
      2'b01:   return jr;
      2'b10:   return (bc == 1'b0 && z == 1'b0) ? seq + 32'(off) : seq;
      default: return seq;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] n;
    if (!rst_n) begin
      m_pc = RESET_VEC; m_cnt = 0;
      m_boot = 1; m_run = 0; m_halt = 0; m_trap = 0;
    end else if (m_boot) begin
      m_boot = 0; m_run = 1;
    end else if (m_run && !stall) begin
      n = model_next(m_pc, instr, pc_sel, branch_ctrl, alu_zero, jr_target);
`ifdef PC_MISALIGN_TRAP_EN
      if (n % 4 != 0) begin
        m_trap = 1; m_run = 0;
      end else
`endif
      begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (n == m_pc) begin m_halt = 1; m_run = 0; end
        m_pc = n;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      check("pc", pc, m_pc);
      check("pc_addr", 32'(pc_addr), 32'(m_pc % (1 << ADDR_W)));
      check("link_addr", link_addr, m_pc + 32'd4);
      check("fetch_valid", 32'(fetch_valid), 32'(m_run));
      check("halted", 32'(halted), 32'(m_halt || m_trap));
      check("instr_count", instr_count, m_cnt);
`ifdef PC_MISALIGN_TRAP_EN
      check("trap", 32'(trap), 32'(m_trap));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_seq();
    instr = ADDI; pc_sel = 2'b10; branch_ctrl = 1'b1; alu_zero = 1'b0; stall = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    int          stop_wait;

    // Reset and BOOT
    set_seq();
    tick(); tick();
    check_en = 1'b1;
    check("rst_pc", pc, 32'h0);
    check("rst_count", instr_count, 32'h0);
    check("rst_valid", 32'(fetch_valid), 32'h0);
    rst_n = 1'b1;
    check("boot_valid", 32'(fetch_valid), 32'h0);
    tick();
    check("boot_pc_hold", pc, 32'h0);
    check("run_valid", 32'(fetch_valid), 32'h1);
    tick();
    check("seq_pc4", pc, 32'h4);
    tick();
    check("seq_pc8", pc, 32'h8);
    check("count2", instr_count, 32'd2);

    // bne taken back to 0, then not taken
    instr = 32'h1420_FFFD; branch_ctrl = 1'b0; alu_zero = 1'b0;
    tick();
    check("bne_taken", pc, 32'h0);
    set_seq(); tick(); tick();
    instr = 32'h1420_FFFD; branch_ctrl = 1'b0; alu_zero = 1'b1;
    tick();
    check("bne_not_taken", pc, 32'hC);
    set_seq(); tick();
    check("pc10", pc, 32'h10);

    // jal
    instr = 32'h0C00_0040; pc_sel = 2'b00;
    #1 check("jal_link", link_addr, 32'h14);
    tick();
    check("jal_pc", pc, 32'h100);

    // jr then stall
    pc_sel = 2'b01; jr_target = 32'h24;
    tick();
    check("jr_pc", pc, 32'h24);
    check("count9", instr_count, 32'd9);
    stall = 1'b1; pc_sel = 2'b10;
    tick(); tick(); tick();
    check("stall_pc", pc, 32'h24);
    check("stall_count", instr_count, 32'd9);
    set_seq(); tick(); tick(); tick();
    check("pc30", pc, 32'h30);

    // j . -> HALT
    instr = 32'h0800_000C; pc_sel = 2'b00;
    tick();
    check("halt_count", instr_count, 32'd13);
    check("halted", 32'(halted), 32'h1);
    check("halt_valid", 32'(fetch_valid), 32'h0);
    set_seq(); tick(); tick();
    check("halt_pc_frozen", pc, 32'h30);
    check("halt_count_frozen", instr_count, 32'd13);

    // asynchronous reset mid-cycle
    #1 rst_n = 1'b0;
    #1 check("async_rst_pc", pc, 32'h0);
    check("async_rst_halted", 32'(halted), 32'h0);
    tick();
    rst_n = 1'b1;

`ifdef PC_MISALIGN_TRAP_EN
    // misaligned jr traps
    tick();
    repeat (7) tick();
    check("pc1c", pc, 32'h1C);
    pc_sel = 2'b01; jr_target = 32'h22;
    tick();
    check("trap_flag", 32'(trap), 32'h1);
    check("trap_halted", 32'(halted), 32'h1);
    check("trap_pc", pc, 32'h1C);
    check("trap_count", instr_count, 32'd7);
    tick(); tick();
    check("trap_sticky", 32'(trap), 32'h1);
    #1 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`endif

    // randomized traffic against the model
    stop_wait = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_halt || m_trap) stop_wait++;
      if (stop_wait > 3 || $urandom_range(0, 299) == 0) begin
        stop_wait = 0;
        #1 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      instr       = $urandom;
      pc_sel      = 2'($urandom_range(0, 3));
      branch_ctrl = 1'($urandom_range(0, 1));
      alu_zero    = 1'($urandom_range(0, 1));
      stall       = ($urandom_range(0, 3) == 0);
      r           = $urandom;
      jr_target   = ($urandom_range(0, 7) == 0) ? r : (r & 32'hFFFF_FFFC);
      if ($urandom_range(0, 39) == 0) begin
        pc_sel = 2'b01; jr_target = m_pc;
      end
      tick();
    end

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
